seq_borrow_lookahead_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/borrow_lookahead_slice_4.sv | 44 ++++
 rtl/seq_borrow_lookahead_subtractor.sv | 127 ++++++++++++
 tb/tb_seq_borrow_lookahead_subtractor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types.
// FSM encoding and slice width for multi-cycle arithmetic blocks.
package arith_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_t;

endpackage

// File: rtl/borrow_lookahead_slice_4.sv
// 4-bit borrow-lookahead subtract slice.
// Borrows are fully expanded from bin; group p/g kept for 2-level use.
import arith_pkg::*;

module borrow_lookahead_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       gp,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Each borrow is a flat sum of products of g, p and bin.
  always_comb begin
    c[0] = bin;
    c[1] = g[0] | (p[0] & bin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & bin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & bin);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bin);
  end

  assign d    = a ^ b ^ c[3:0];
  assign bout = c[4];
  assign gp   = &p;
  assign gg   = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/seq_borrow_lookahead_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit slice per clock.
// Borrow is registered between slices; valid/ready on both sides.
import arith_pkg::*;

module seq_borrow_lookahead_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  arith_state_t state;
  arith_state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] d_s;
  logic       bout_s;
  logic       gp_s;
  logic       gg_s;
  logic       accept;
  logic       release_r;
  logic       last;

  assign a_s = a_q[k*SLICE_W +: SLICE_W];
  assign b_s = b_q[k*SLICE_W +: SLICE_W];
  assign last = (k == KW'(NSLICE - 1));

  borrow_lookahead_slice_4 u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (c_q),
    .d    (d_s),
    .bout (bout_s),
    .gp   (gp_s),
    .gg   (gg_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    release_r = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        release_r = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, per-slice writeback and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      k      <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      c_q    <= bin;
      k      <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN) begin
      diff_q[k*SLICE_W +: SLICE_W] <= d_s;
      c_q <= bout_s;
      if (last) begin
        k      <= '0;
        bout_q <= bout_s;
        ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                & (d_s[3] ^ a_q[WIDTH-1]);
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_borrow_lookahead_subtractor.sv
// Bench for seq_borrow_lookahead_subtractor.
// Directed and random operations against an integer reference model.
module tb_seq_borrow_lookahead_subtractor;

  localparam int W = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  seq_borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic tbin,
                       input int stall,
                       input bit early);
    int ua, ub, sa, sb, ud, sd, n;
    logic [W-1:0] ediff;
    logic ebout, eovf;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    ud = ua - ub - int'(tbin);
    sd = sa - sb - int'(tbin);
    ediff = W'(ud);
    ebout = (ud < 0);
    eovf = (sd > 32767) || (sd < -32768);

    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    out_ready = early;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, NS);
    chk("diff", diff, ediff);
    chk("bout", bout, ebout);
    chk("ovf", ovf, eovf);
    if (stall > 0) out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      tick();
      chk("hold_diff", diff, ediff);
      chk("hold_bout", bout, ebout);
      chk("hold_ovf", ovf, eovf);
      chk("hold_irdy", in_ready, 0);
      chk("hold_ovld", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_irdy", in_ready, 1);
    chk("rel_ovld", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_irdy", in_ready, 1);
    chk("rst_ovld", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);

    do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    do_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 5, 1'b0);

    // Reset after two slices of an operation.
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ovld", out_valid, 0);
    chk("mid_diff", diff, 0);
    chk("mid_irdy", in_ready, 1);
    do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
